// File: rtl/mem_write_tracer_pkg.sv
// Shared constants for the data-memory write tracer: default sizing and
// the bit layout of a trace record {seq, addr, data}.
package mips_trace_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int SEQ_W_DEF = 8;

  // Record fields, LSB first: data, then address, then sequence number.
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 32;
  localparam int SEQ_LSB  = 64;
  localparam int REC_W    = 64 + SEQ_W_DEF;

  function automatic int rec_width(input int seq_w);
    return 64 + seq_w;
  endfunction

endpackage

// File: rtl/mem_write_tracer_if.sv
// Processor write-snoop inputs plus the trace-record output stream.
interface mem_write_tracer_if import mips_trace_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic             memwrite;
  logic [31:0]      dataadr;
  logic [31:0]      writedata;
  logic             trace_en;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [SEQ_W-1:0] out_seq;
  logic [CW-1:0]    count;
  logic [7:0]       drop_cnt;

  modport master (
    output memwrite, dataadr, writedata, trace_en, out_ready,
    input  out_valid, out_addr, out_data, out_seq, count, drop_cnt
  );

  modport slave (
    input  memwrite, dataadr, writedata, trace_en, out_ready,
    output out_valid, out_addr, out_data, out_seq, count, drop_cnt
  );

endinterface

// File: rtl/mem_write_tracer_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is read straight
// from storage so a record written on one edge is visible right after it.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_tracer.sv
// Captures processor data-memory writes into a trace FIFO, tagging each with
// a sequence number; writes lost to a full FIFO leave gaps and bump drop_cnt.
module mem_write_tracer import mips_trace_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_write_tracer_if.slave  bus
);

  localparam int RW = rec_width(SEQ_W);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             capture;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [RW-1:0]    din;
  logic [RW-1:0]    dout;
  logic [CW-1:0]    fifo_count;
  logic [SEQ_W-1:0] seq_reg;
  logic [7:0]       drop_reg;

  assign capture = bus.memwrite && bus.trace_en;
  assign pop     = !empty && bus.out_ready;
  assign push    = capture && (!full || pop);
  assign din     = {seq_reg, bus.dataadr, bus.writedata};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Sequence advances on every capture, kept or dropped, so drops show as gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_reg  <= '0;
      drop_reg <= '0;
    end else begin
      if (capture) seq_reg <= seq_reg + 1'b1;
      if (capture && full && !pop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_addr  = dout[ADDR_LSB +: 32];
  assign bus.out_data  = dout[DATA_LSB +: 32];
  assign bus.out_seq   = dout[SEQ_LSB +: SEQ_W];
  assign bus.count     = fifo_count;
  assign bus.drop_cnt  = drop_reg;

endmodule

// File: tb/tb_mem_write_tracer.sv
// Directed bench for mem_write_tracer with a queue-based reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_mem_write_tracer;
  import mips_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 8;

  typedef struct {
    int unsigned seq;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic clk;
  logic reset;

  mem_write_tracer_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) bus ();

  mem_write_tracer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rec_t        model_q[$];
  rec_t        mon_q[$];
  int unsigned model_seq  = 0;
  int unsigned model_drop = 0;
  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of records driven by the capture rules.
  always @(posedge clk) begin : model_upd
    bit pm;
    bit cm;
    if (reset) begin
      model_q.delete();
      model_seq  = 0;
      model_drop = 0;
    end else begin
      pm = (model_q.size() != 0) && (bus.out_ready === 1'b1);
      cm = (bus.memwrite === 1'b1) && (bus.trace_en === 1'b1);
      if (pm) void'(model_q.pop_front());
      if (cm) begin
        if (model_q.size() < DEPTH) model_q.push_back('{model_seq, bus.dataadr, bus.writedata});
        else if (model_drop < 255) model_drop++;
        model_seq = (model_seq + 1) % (1 << SEQ_W);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", bus.out_valid, model_q.size() != 0);
      check("count", bus.count, model_q.size());
      check("drop_cnt", bus.drop_cnt, model_drop);
      if (model_q.size() != 0) begin
        check("head_seq", bus.out_seq, model_q[0].seq);
        check("head_addr", bus.out_addr, model_q[0].addr);
        check("head_data", bus.out_data, model_q[0].data);
      end
    end
  end

  // Records that will leave on the coming edge, one line each.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      mon_q.push_back('{bus.out_seq, bus.out_addr, bus.out_data});
      $display("pop seq=%0d addr=%08h data=%08h", bus.out_seq, bus.out_addr, bus.out_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] t_addr [11] = '{32'h47, 32'h43, 32'h42, 32'h44, 32'h45, 32'h46,
                               32'h49, 32'h50, 32'h51, 32'h52, 32'h53};
  logic [31:0] t_data [11] = '{32'h65, 32'h1, 32'h7, 32'h7, 32'h0, 32'h1,
                               32'h65, 32'ha, 32'hd, 32'ha, 32'hd};

  initial begin
    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.trace_en  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_drop", bus.drop_cnt, 0);

    // Single write, one-cycle latency, then popped.
    bus.out_ready = 1'b1;
    wr(32'h47, 32'h65);
    @(negedge clk);
    check("single_valid", bus.out_valid, 1'b1);
    check("single_addr", bus.out_addr, 32'h47);
    check("single_data", bus.out_data, 32'h65);
    check("single_seq", bus.out_seq, 0);
    tick();
    @(negedge clk);
    check("single_count_after_pop", bus.count, 0);

    // Eleven back-to-back writes with a ready consumer.
    do_reset();
    mon_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) wr(t_addr[i], t_data[i]);
    repeat (3) tick();
    check("b2b_n", mon_q.size(), 11);
    for (int i = 0; i < 11 && i < mon_q.size(); i++) begin
      check("b2b_seq", mon_q[i].seq, i);
      check("b2b_addr", mon_q[i].addr, t_addr[i]);
      check("b2b_data", mon_q[i].data, t_data[i]);
    end
    check("b2b_drop", bus.drop_cnt, 0);

    // Overflow: ten writes into an eight-entry FIFO with no consumer.
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) wr(32'h100 + i, i);
    @(negedge clk);
    check("ovf_count", bus.count, 8);
    check("ovf_drop", bus.drop_cnt, 2);
    mon_q.delete();
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("ovf_n", mon_q.size(), 8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      check("ovf_seq", mon_q[i].seq, i);
      check("ovf_addr", mon_q[i].addr, 32'h100 + i);
    end
    bus.out_ready = 1'b0;
    wr(32'h1ff, 32'h55);
    @(negedge clk);
    check("ovf_next_seq", bus.out_seq, 10);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) wr(32'h200 + i, 32'h1000 + i);
    @(negedge clk);
    check("fullpp_pre_count", bus.count, 8);
    mon_q.delete();
    bus.out_ready = 1'b1;
    wr(32'h2ff, 32'hbeef);
    @(negedge clk);
    check("fullpp_count", bus.count, 8);
    check("fullpp_drop", bus.drop_cnt, 0);
    repeat (10) tick();
    check("fullpp_n", mon_q.size(), 9);
    if (mon_q.size() == 9) begin
      check("fullpp_first_addr", mon_q[0].addr, 32'h200);
      check("fullpp_last_addr", mon_q[8].addr, 32'h2ff);
      check("fullpp_last_data", mon_q[8].data, 32'hbeef);
      check("fullpp_last_seq", mon_q[8].seq, 8);
    end

    // Reset mid-operation together with a write.
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'h300 + i, i);
    @(negedge clk);
    check("midrst_pre_count", bus.count, 5);
    reset         = 1'b1;
    bus.memwrite  = 1'b1;
    bus.dataadr   = 32'h3ff;
    tick();
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_count", bus.count, 0);
    check("midrst_drop", bus.drop_cnt, 0);
    wr(32'h400, 32'h1);
    @(negedge clk);
    check("midrst_seq", bus.out_seq, 0);

    // 300 captures drained continuously: sequence wraps without gaps.
    do_reset();
    mon_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) wr(i, ~i);
    repeat (3) tick();
    check("wrap_n", mon_q.size(), 300);
    for (int i = 0; i < 300 && i < mon_q.size(); i++) check("wrap_seq", mon_q[i].seq, i % 256);

    // Writes while tracing is disabled leave no trace and no sequence step.
    bus.trace_en = 1'b0;
    bus.memwrite = 1'b1;
    repeat (3) tick();
    bus.memwrite = 1'b0;
    bus.trace_en = 1'b1;
    @(negedge clk);
    check("gate_valid", bus.out_valid, 1'b0);
    check("gate_count", bus.count, 0);
    bus.out_ready = 1'b0;
    wr(32'h500, 32'h7);
    @(negedge clk);
    check("gate_seq", bus.out_seq, 44);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_tracer.md
MEM_WRITE_TRACER -- requirements
Module: mem_write_tracer

Interface
REQ-001 Parameter DEPTH, default 8, number of trace FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter SEQ_W, default 8, width of the write sequence number.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 memwrite  input  1  processor data-memory write strobe, one write per cycle when high.
REQ-006 dataadr  input  32  processor data-memory address of the write.
REQ-007 writedata  input  32  processor data-memory write data.
REQ-008 trace_en  input  1  high enables capture; low ignores memwrite entirely (no capture, no sequence increment).
REQ-009 out_valid  output  1  a trace record is presented at the FIFO head.
REQ-010 out_ready  input  1  consumer accepts the head record when out_valid is high.
REQ-011 out_addr  output  32  address field of the head record.
REQ-012 out_data  output  32  data field of the head record.
REQ-013 out_seq  output  SEQ_W  sequence number of the head record.
REQ-014 count  output  clog2(DEPTH)+1  number of records currently stored.
REQ-015 drop_cnt  output  8  saturating count of writes lost to a full FIFO.

Function
REQ-016 A capture event SHALL be memwrite=1 and trace_en=1 at a rising edge with reset=0.
REQ-017 Each capture event SHALL be assigned the current sequence counter value, and the counter SHALL then increment by 1, wrapping from 2^SEQ_W-1 to 0.
REQ-018 The sequence counter SHALL increment on dropped captures too, so that consumers see drops as gaps in out_seq.
REQ-019 A capture SHALL be pushed as {seq, dataadr, writedata} when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-020 A capture SHALL be dropped when the FIFO is full and no pop occurs on the same edge; drop_cnt SHALL then increment, saturating at 255.
REQ-021 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL equal (count != 0); out_addr, out_data and out_seq SHALL show the oldest stored record (first-word fall-through).
REQ-023 A capture at edge N into an empty FIFO SHALL make out_valid high in the cycle following edge N, giving one-cycle latency.
REQ-024 On an edge with both a push and a pop, count SHALL be unchanged and record order SHALL be preserved.
REQ-025 The head fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=0, out_addr, out_data and out_seq SHALL be don't-care.
REQ-027 out_ready with an empty FIFO SHALL have no effect.
REQ-028 The read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While reset=1 at an edge, the following SHALL clear to 0: read and write pointers, count, the sequence counter and drop_cnt. out_valid SHALL be 0 in the following cycle.
REQ-030 Reset SHALL take priority over any simultaneous capture or pop, which SHALL be discarded.
REQ-031 FIFO storage contents SHALL need no reset.

Structure
REQ-032 Package mips_trace_pkg SHALL hold the DEPTH and SEQ_W defaults, the record width constant (64+SEQ_W), and the trace record field-offset constants.
REQ-033 Storage and pointers SHALL be one sub-module, trace_fifo (synchronous FWFT FIFO with push, pop, full, empty, count); the sequence and drop logic SHALL stay in mem_write_tracer.

Verification
REQ-034 Single write: memwrite=1 with dataadr=0x47 and writedata=0x65, then out_ready=1 -> the next cycle shows out_valid=1, out_addr=0x47, out_data=0x65, out_seq=0; count returns to 0 after the pop.
REQ-035 Eleven back-to-back writes with out_ready=1, pairs (0x47,0x65) (0x43,0x1) (0x42,0x7) (0x44,0x7) (0x45,0x0) (0x46,0x1) (0x49,0x65) (0x50,0xa) (0x51,0xd) (0x52,0xa) (0x53,0xd) -> the records emerge in the same order with out_seq 0..10 and drop_cnt=0.
REQ-036 Overflow: out_ready=0 with 10 writes at DEPTH=8 -> count=8 and drop_cnt=2; the drained records carry out_seq 0..7; the next capture carries out_seq 10.
REQ-037 Full with simultaneous push and pop: FIFO full, out_ready=1, memwrite=1 -> count stays 8, drop_cnt is unchanged, and the new record is last out.
REQ-038 Reset mid-operation: 5 records stored, then reset=1 for one edge together with memwrite=1 -> out_valid=0, count=0, drop_cnt=0; the next capture carries out_seq 0.
REQ-039 Wrap and gating: 300 captures drained continuously -> out_seq wraps 255->0 with no gaps; memwrite=1 while trace_en=0 -> no record and no sequence increment.
